ux607_itcm_ram_ctrl: RTL and testbench

- Requester-side controller driving the ITCM RAM macro port (cs/addr/wem/din/dout, 1-cycle read latency).
- Accepts valid/ready commands from the core/bus side and issues RAM accesses.
- Captures dout one cycle after each access and returns in-order responses through a 2-entry response buffer, giving full throughput under backpressure.
- Drives the RAM power pins (sd/ds/ls).

---
 rtl/ux607_itcm_ram_ctrl_pkg.sv | 35 +++
 rtl/ux607_itcm_ram_ctrl_if.sv | 32 +++
 rtl/ux607_itcm_rsp_fifo.sv | 57 +++++
 rtl/ux607_itcm_ram_ctrl.sv | 137 +++++++++++++
 tb/tb_ux607_itcm_ram_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ux607_itcm_ram_ctrl_pkg.sv
// Shared definitions for the ITCM RAM controller.
//   ITCM_CTRL_RSP_DEPTH : response buffer depth
//   ITCM_CTRL_DW        : data width the response entry type is built for
//   rsp_entry_t         : one buffered response {is_write, rdata}
//   ls_state_e          : light-sleep FSM states (used with UX607_ITCM_RAM_CTRL_LS_EN)
//   ptr_inc()           : response-buffer pointer increment with wrap
package ux607_itcm_ram_ctrl_pkg;

  localparam int unsigned ITCM_CTRL_RSP_DEPTH = 2;
  localparam int unsigned ITCM_CTRL_DW        = 64;
  localparam int unsigned ITCM_CTRL_CNT_W     = $clog2(ITCM_CTRL_RSP_DEPTH + 1);
  localparam int unsigned ITCM_CTRL_PTR_W     =
      (ITCM_CTRL_RSP_DEPTH > 1) ? $clog2(ITCM_CTRL_RSP_DEPTH) : 1;

  typedef struct packed {
    logic                    is_write;
    logic [ITCM_CTRL_DW-1:0] rdata;
  } rsp_entry_t;

  typedef enum logic [1:0] {
    LsActive,
    LsSleep,
    LsWake
  } ls_state_e;

  function automatic logic [ITCM_CTRL_PTR_W-1:0] ptr_inc(
    input logic [ITCM_CTRL_PTR_W-1:0] ptr
  );
    if (ptr == ITCM_CTRL_PTR_W'(ITCM_CTRL_RSP_DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/ux607_itcm_ram_ctrl_if.sv
// Command/response handshake bundle between the core side and the ITCM controller.
//   cmd_*  : command channel (valid/ready), read flag, word address, write data, byte mask
//   rsp_*  : in-order response channel (valid/ready), read data, write flag
// Modports: master = core/bus side, slave = controller.
interface ux607_itcm_ram_ctrl_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 64,
  parameter int unsigned MW = 8
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_write
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_write
  );

endinterface

// File: rtl/ux607_itcm_rsp_fifo.sv
// Small synchronous response FIFO (depth ITCM_CTRL_RSP_DEPTH), sync active-high reset.
//   clk, rst   : clock, synchronous reset
//   push       : write push_data (caller guarantees room)
//   out_valid  : head entry present; out_ready pops it
//   out_data   : head entry, zero while empty
//   count      : number of stored entries
module ux607_itcm_rsp_fifo
  import ux607_itcm_ram_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rsp_entry_t                 push_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output rsp_entry_t                 out_data,
  output logic [ITCM_CTRL_CNT_W-1:0] count
);

  rsp_entry_t                 mem_q [ITCM_CTRL_RSP_DEPTH];
  logic [ITCM_CTRL_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ITCM_CTRL_CNT_W-1:0] cnt_q;
  logic                       pop;

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ux607_itcm_ram_ctrl.sv
// ITCM RAM requester-side controller.
// Issues accepted commands straight to the RAM port, captures ram_dout one cycle later and
// returns in-order responses through a 2-entry buffer (full throughput under backpressure).
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : cmd valid/ready + read/addr/wdata/wmask, rsp valid/ready + rdata/write
//   ram_cs/addr/wem/din, ram_dout : RAM macro port, 1-cycle read latency
//   ram_sd/ds/ls  : RAM power pins (sd/ds tied low)
// Optional: define UX607_ITCM_RAM_CTRL_LS_EN to enter light sleep after LS_IDLE idle cycles.
module ux607_itcm_ram_ctrl
  import ux607_itcm_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = ITCM_CTRL_DW,
  parameter int unsigned MW      = 8,
  parameter int unsigned LS_IDLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ux607_itcm_ram_ctrl_if.slave  bus,
  output logic                  ram_cs,
  output logic [AW-1:0]         ram_addr,
  output logic [MW-1:0]         ram_wem,
  output logic [DW-1:0]         ram_din,
  input  logic [DW-1:0]         ram_dout,
  output logic                  ram_sd,
  output logic                  ram_ds,
  output logic                  ram_ls
);

  logic                       accept, pop, ls_block;
  logic                       infl_q, infl_write_q;
  logic [ITCM_CTRL_CNT_W-1:0] fifo_cnt, occupancy;
  rsp_entry_t                 push_entry, head;

  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  // In-flight access plus buffered entries may never exceed the buffer depth, so a
  // response always has room when it lands; a same-cycle pop frees one slot.
  assign occupancy     = ITCM_CTRL_CNT_W'(infl_q) + fifo_cnt;
  assign bus.cmd_ready = ~rst & ~ls_block &
                         ((occupancy < ITCM_CTRL_CNT_W'(ITCM_CTRL_RSP_DEPTH)) | pop);

  assign ram_cs   = accept;
  assign ram_addr = bus.cmd_addr;
  assign ram_din  = bus.cmd_wdata;
  assign ram_wem  = (accept & ~bus.cmd_read) ? bus.cmd_wmask : '0;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q       <= 1'b0;
      infl_write_q <= 1'b0;
    end else begin
      infl_q       <= accept;
      infl_write_q <= accept & ~bus.cmd_read;
    end
  end

  always_comb begin
    push_entry          = '0;
    push_entry.is_write = infl_write_q;
    push_entry.rdata    = infl_write_q ? '0 : ram_dout;
  end

  ux607_itcm_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (push_entry),
    .out_valid (bus.rsp_valid),
    .out_ready (bus.rsp_ready),
    .out_data  (head),
    .count     (fifo_cnt)
  );

  assign bus.rsp_rdata = head.rdata;
  assign bus.rsp_write = head.is_write;

`ifdef UX607_ITCM_RAM_CTRL_LS_EN
  localparam int unsigned IdleW = $clog2(LS_IDLE + 1);

  ls_state_e        ls_state_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic             ram_ls_q, waking_q, idle;

  assign idle     = ~accept & ~infl_q & (fifo_cnt == '0);
  // Commands are held off both while asleep and during the single wake cycle.
  assign ls_block = ram_ls_q | waking_q;
  assign ram_ls   = ram_ls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_state_q <= LsActive;
      idle_cnt_q <= '0;
      ram_ls_q   <= 1'b0;
      waking_q   <= 1'b0;
    end else begin
      unique case (ls_state_q)
        LsActive: begin
          if (!idle) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != IdleW'(LS_IDLE)) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
            if (idle_cnt_q == IdleW'(LS_IDLE - 1)) begin
              ls_state_q <= LsSleep;
              ram_ls_q   <= 1'b1;
            end
          end
        end
        LsSleep: begin
          if (bus.cmd_valid) begin
            ls_state_q <= LsWake;
            ram_ls_q   <= 1'b0;
            waking_q   <= 1'b1;
            idle_cnt_q <= '0;
          end
        end
        LsWake: begin
          ls_state_q <= LsActive;
          waking_q   <= 1'b0;
        end
        default: begin
          ls_state_q <= LsActive;
          ram_ls_q   <= 1'b0;
          waking_q   <= 1'b0;
        end
      endcase
    end
  end
`else
  assign ls_block = 1'b0;
  assign ram_ls   = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_itcm_ram_ctrl.sv
module tb_ux607_itcm_ram_ctrl;

  logic        clk, rst;
  logic        ram_cs, ram_sd, ram_ds, ram_ls;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din, ram_dout;

  ux607_itcm_ram_ctrl_if #(.AW(16), .DW(64), .MW(8)) bus_if ();

  ux607_itcm_ram_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .ram_cs   (ram_cs),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_sd   (ram_sd),
    .ram_ds   (ram_ds),
    .ram_ls   (ram_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM macro: 1-cycle read latency; dout is garbage whenever no read was issued.
  logic [63:0] ram_mem [0:65535] = '{default: '0};
  always @(posedge clk) begin
    if (ram_cs && ram_wem == 8'h00) ram_dout <= ram_mem[ram_addr];
    else ram_dout <= {$urandom(), $urandom()};
    if (ram_cs && ram_wem != 8'h00) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_din, ram_wem);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: queue of outstanding responses stamped with their accept cycle.
  typedef struct {bit wr; logic [63:0] data; int stamp;} exp_t;
  exp_t q[$];
  logic [63:0] ref_mem [logic [15:0]];
  int cyc = 0;
  bit m_ls = 0, m_wake = 0;
`ifdef UX607_ITCM_RAM_CTRL_LS_EN
  localparam int LS_IDLE = 16;
  int m_idle = 0;
`endif

  function automatic logic [63:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  logic        s_ready, s_cs, s_rv, s_rw, s_ls;
  logic [7:0]  s_wem;
  logic [63:0] s_rdata;

  task automatic step(input bit r, input bit v, input bit rd, input logic [15:0] a,
                      input logic [63:0] wd, input logic [7:0] wm, input bit rr);
    bit exp_rv, exp_rdy, acc;
    exp_t e;
    @(negedge clk);
    rst = r;
    bus_if.cmd_valid = v; bus_if.cmd_read = rd; bus_if.cmd_addr = a;
    bus_if.cmd_wdata = wd; bus_if.cmd_wmask = wm; bus_if.rsp_ready = rr;
    #1;
    s_ready = bus_if.cmd_ready; s_cs = ram_cs; s_wem = ram_wem; s_rv = bus_if.rsp_valid;
    s_rw = bus_if.rsp_write; s_rdata = bus_if.rsp_rdata; s_ls = ram_ls;
    exp_rv  = (q.size() > 0) && (cyc >= q[0].stamp + 2);
    exp_rdy = !r && !m_ls && !m_wake && ((q.size() < 2) || (exp_rv && rr));
    check("cmd_ready", s_ready, exp_rdy);
    check("rsp_valid", s_rv, exp_rv);
    check("ram_ls", s_ls, m_ls);
    check("ram_cs", s_cs, v && exp_rdy);
    check("ram_sd_ds", {ram_sd, ram_ds}, 2'b00);
    acc = v && s_ready;
    if (acc) begin
      check("ram_addr", ram_addr, a);
      check("ram_wem", s_wem, rd ? 8'h00 : wm);
      if (!rd) check("ram_din", ram_din, wd);
    end
    if (exp_rv && s_rv) begin
      check("rsp_write", s_rw, q[0].wr);
      check("rsp_rdata", s_rdata, q[0].data);
    end
    @(posedge clk);
    if (r) begin
      q.delete(); m_ls = 0; m_wake = 0;
`ifdef UX607_ITCM_RAM_CTRL_LS_EN
      m_idle = 0;
`endif
    end else begin
`ifdef UX607_ITCM_RAM_CTRL_LS_EN
      begin
        bit idle = !acc && q.size() == 0;
        if (m_wake) m_wake = 0;
        else if (m_ls) begin
          if (v) begin m_ls = 0; m_wake = 1; end
        end else begin
          m_idle = idle ? m_idle + 1 : 0;
          if (m_idle >= LS_IDLE) begin m_ls = 1; m_idle = 0; end
        end
      end
`endif
      if (exp_rv && rr) void'(q.pop_front());
      if (acc) begin
        e.wr = !rd; e.stamp = cyc;
        e.data = rd ? ref_rd(a) : 64'h0;
        if (!rd) ref_mem[a] = merge(ref_rd(a), wd, wm);
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  typedef struct {
    bit rd; logic [15:0] addr; logic [63:0] wdata; logic [7:0] wmask;
    logic [7:0] exp_wem; bit exp_w; logic [63:0] exp_rdata;
  } vec_t;
  localparam int NV = 8;
  vec_t tbl [NV];

  initial begin
    int acc_n, rv_n;
    tbl[0] = '{0, 16'h10, 64'hDEADBEEF_01234567, 8'hFF, 8'hFF, 1, 64'h0};
    tbl[1] = '{1, 16'h10, 64'h0,                 8'h00, 8'h00, 0, 64'hDEADBEEF_01234567};
    tbl[2] = '{0, 16'h10, 64'h11223344_55667788, 8'h0F, 8'h0F, 1, 64'h0};
    tbl[3] = '{1, 16'h10, 64'h0,                 8'hFF, 8'h00, 0, 64'hDEADBEEF_55667788};
    tbl[4] = '{0, 16'h20, 64'hAAAAAAAA_AAAAAAAA, 8'h00, 8'h00, 1, 64'h0};
    tbl[5] = '{1, 16'h20, 64'h0,                 8'h00, 8'h00, 0, 64'h0};
    tbl[6] = '{0, 16'h20, 64'h01234567_89ABCDEF, 8'h81, 8'h81, 1, 64'h0};
    tbl[7] = '{1, 16'h20, 64'h0,                 8'h00, 8'h00, 0, 64'h01000000_000000EF};

    rst = 1'b1;
    bus_if.cmd_valid = 0; bus_if.cmd_read = 1; bus_if.cmd_addr = '0;
    bus_if.cmd_wdata = '0; bus_if.cmd_wmask = '0; bus_if.rsp_ready = 1;
    @(posedge clk);

    // Reset state
    step(1, 1, 1, 16'h10, 64'h0, 8'h0, 1);
    check("rst_cmd_ready", s_ready, 0);
    check("rst_ram_cs", s_cs, 0);
    step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    check("post_rst_rsp_valid", s_rv, 0);
    check("post_rst_rdata", s_rdata, 64'h0);
    check("post_rst_ram_ls", s_ls, 0);

    // Table: back-to-back issue, response exactly two cycles after accept
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) step(0, 1, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, 1);
      else step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
      if (i < NV) begin
        check("tbl_cmd_ready", s_ready, 1);
        check("tbl_ram_wem", s_wem, tbl[i].exp_wem);
      end
      if (i >= 2) begin
        check("tbl_rsp_valid", s_rv, 1);
        check("tbl_rsp_write", s_rw, tbl[i-2].exp_w);
        check("tbl_rsp_rdata", s_rdata, tbl[i-2].exp_rdata);
      end else begin
        check("tbl_rsp_empty", s_rv, 0);
      end
    end

    // 8 back-to-back reads, full throughput
    for (int i = 0; i < 10; i++) begin
      step(0, i < 8, 1, (i % 2) ? 16'h20 : 16'h10, 64'h0, 8'h0, 1);
      if (i < 8) check("b2b_cmd_ready", s_ready, 1);
      check("b2b_rsp_valid", s_rv, i >= 2);
    end

    // Backpressure: only two accepts, then drain in order
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, (i % 2) ? 16'h10 : 16'h20, 64'h0, 8'h0, 0);
      if (s_ready) acc_n++;
    end
    check("bp_accepts", acc_n, 2);
    check("bp_cmd_ready_low", s_ready, 0);
    check("bp_rsp_held", s_rv, 1);
    rv_n = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
      if (s_rv) rv_n++;
    end
    check("bp_drain_count", rv_n, 2);
    check("bp_drained", s_rv, 0);

    // Reset while a read is in flight drops it
    step(0, 1, 1, 16'h20, 64'h0, 8'h0, 1);
    step(1, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    check("midrst_rsp_valid", s_rv, 0);
    check("midrst_ram_cs", s_cs, 0);
    step(0, 1, 1, 16'h10, 64'h0, 8'h0, 1);
    step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    check("midrst_next_valid", s_rv, 1);
    check("midrst_next_rdata", s_rdata, 64'hDEADBEEF_55667788);

    // Light sleep
    for (int i = 0; i < 20; i++) step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
`ifdef UX607_ITCM_RAM_CTRL_LS_EN
    check("ls_entered", s_ls, 1);
    step(0, 1, 1, 16'h10, 64'h0, 8'h0, 1);
    check("ls_sleep_ready", s_ready, 0);
    step(0, 1, 1, 16'h10, 64'h0, 8'h0, 1);
    check("ls_wake_ls", s_ls, 0);
    check("ls_wake_ready", s_ready, 0);
    step(0, 1, 1, 16'h10, 64'h0, 8'h0, 1);
    check("ls_accept", s_ready, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
`else
    check("ls_disabled", s_ls, 0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
           16'($urandom_range(15)), {$urandom(), $urandom()},
           ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom()), $urandom_range(3) != 0);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h0, 64'h0, 8'h0, 1);
    check("final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
